// File: rtl/muldiv_ctrl.sv
// Sequencing controller between EX and the iterative multiplier/divider:
// issues start pulses, stalls EX until completion, and writes {HI,LO}.
module muldiv_ctrl #(
   parameter int unsigned WATCHDOG_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid_E,
   input  logic [1:0]  op_E,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush_E,
   input  logic        stall_M,
   output logic        mult_start,
   output logic        div_start,
   output logic        unit_signed,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        unit_cancel,
   input  logic        mult_done,
   input  logic        div_done,
   input  logic [63:0] mult_result,
   input  logic [63:0] div_result,
   output logic        stall_E,
   output logic        hilo_we,
   output logic [63:0] hilo_wdata,
   output logic        busy,
   output logic        err
);

   localparam int unsigned CW = $clog2(WATCHDOG_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_MBUSY, S_DBUSY, S_DONE} state_t;

   state_t        r_state, w_state_nx;
   logic [CW-1:0] r_wdog;
   logic          r_zero, r_mstart, r_dstart, r_signed, r_cancel, r_err;
   logic [31:0]   r_a, r_b;
   logic [63:0]   r_wdata;

   logic w_load, w_mstart, w_dstart, w_cancel, w_err, w_abort, w_capture;
   logic w_unit_done, w_wdog_last, w_stall, w_we;

   assign w_wdog_last = (r_wdog == CW'(WATCHDOG_CYCLES - 1));
   assign w_unit_done = (r_state == S_MBUSY) ? mult_done : div_done;

   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_mstart   = 1'b0;
      w_dstart   = 1'b0;
      w_cancel   = 1'b0;
      w_err      = 1'b0;
      w_abort    = 1'b0;
      w_capture  = 1'b0;
      w_stall    = 1'b0;
      w_we       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (op_valid_E && !flush_E) begin
               w_stall = 1'b1;
               w_load  = 1'b1;
               if (op_E[1] && (src_b == '0)) begin
                  w_state_nx = S_DONE;
               end else if (op_E[1]) begin
                  w_state_nx = S_DBUSY;
                  w_dstart   = 1'b1;
               end else begin
                  w_state_nx = S_MBUSY;
                  w_mstart   = 1'b1;
               end
            end
         end
         S_MBUSY, S_DBUSY: begin
            // Flush beats a same-cycle done; done beats the watchdog.
            w_stall = ~flush_E;
            if (flush_E) begin
               w_state_nx = S_IDLE;
               w_cancel   = 1'b1;
            end else if (w_unit_done) begin
               w_state_nx = S_DONE;
               w_capture  = 1'b1;
            end else if (w_wdog_last) begin
               w_state_nx = S_DONE;
               w_cancel   = 1'b1;
               w_err      = 1'b1;
               w_abort    = 1'b1;
            end
         end
         S_DONE: begin
            w_stall = stall_M;
            w_we    = ~r_zero & ~stall_M & ~flush_E;
            if (flush_E || !stall_M) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_wdog   <= '0;
         r_zero   <= 1'b0;
         r_mstart <= 1'b0;
         r_dstart <= 1'b0;
         r_signed <= 1'b0;
         r_cancel <= 1'b0;
         r_err    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_wdata  <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_mstart <= w_mstart;
         r_dstart <= w_dstart;
         r_cancel <= w_cancel;
         r_err    <= w_err;
         if (w_load) begin
            r_a      <= src_a;
            r_b      <= src_b;
            r_signed <= ~op_E[0];
            r_zero   <= op_E[1] & (src_b == '0);
            r_wdog   <= '0;
         end else if ((r_state == S_MBUSY) || (r_state == S_DBUSY)) begin
            r_wdog <= r_wdog + CW'(1);
         end
         if (w_abort) r_zero <= 1'b1;
         if (w_capture) r_wdata <= (r_state == S_MBUSY) ? mult_result : div_result;
      end
   end

   assign mult_start  = r_mstart;
   assign div_start   = r_dstart;
   assign unit_signed = r_signed;
   assign unit_a      = r_a;
   assign unit_b      = r_b;
   assign unit_cancel = r_cancel;
   assign err         = r_err;
   assign hilo_wdata  = r_wdata;
   assign stall_E     = w_stall;
   assign hilo_we     = w_we;
   assign busy        = (r_state != S_IDLE);

endmodule
